mm2s_reader: RTL and testbench

- AXI-Lite read master. Fetches a contiguous vector of words from DDR and presents it as an AXI-Stream with an end-of-vector marker.
- One instance per input vector (x and y) sits directly upstream of the floating-point vector adder, driving its in_*_data/valid/ready/end ports.
- Configured per transfer with base address, length and a start pulse from the PS register adapter.
- Overlaps read requests with stream output through a small credit-controlled buffer.

---
 rtl/mm2s_reader.sv | 158 +++++++++++++++
 tb/tb_mm2s_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm2s_reader.sv
// AXI-Lite read master that fetches a contiguous word vector and replays it as a stream.
// A small credit-controlled FIFO lets address issue overlap with stream output.
module mm2s_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  cfg_start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH:0]    len_ext;
  logic [LEN_WIDTH:0]    issued_cnt;
  logic [LEN_WIDTH:0]    sent_cnt;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           in_flight;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  start_acc;
  logic                  credit_ok;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  pop;
  logic                  last_pop;

  // Every read in flight owns a FIFO slot, so a returning word always has room.
  assign len_ext   = {1'b0, len_q};
  assign in_flight = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok = in_flight < (CW+1)'(FIFO_DEPTH);
  assign start_acc = (state == IDLE) && cfg_start;

  assign arvalid = (state == RUN) && (issued_cnt < len_ext) && credit_ok;
  assign raddr   = base_q + ADDR_WIDTH'(issued_cnt) * ADDR_WIDTH'(BYTES);
  assign rready  = (state == RUN) || (state == DRAIN);
  assign busy    = rready;
  assign done    = (state == DONE);

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign out_last  = out_valid && (sent_cnt == len_ext - (LEN_WIDTH+1)'(1));
  assign pop       = out_valid && out_ready;
  assign last_pop  = pop && (sent_cnt + (LEN_WIDTH+1)'(1) == len_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The final stream beat ends the transfer even if it coincides with the issue phase.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_pop) begin
          state_nxt = DONE;
        end else if (ar_hs && (issued_cnt + (LEN_WIDTH+1)'(1) == len_ext)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      len_q       <= '0;
      issued_cnt  <= '0;
      sent_cnt    <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (start_acc) begin
      base_q      <= cfg_base;
      len_q       <= cfg_len;
      issued_cnt  <= '0;
      sent_cnt    <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (ar_hs) begin
        issued_cnt <= issued_cnt + (LEN_WIDTH+1)'(1);
      end
      if (r_hs) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        sent_cnt <= sent_cnt + (LEN_WIDTH+1)'(1);
      end
      case ({ar_hs, r_hs})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      case ({r_hs, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (r_hs) begin
      mem[wr_ptr] <= rdata;
    end
  end

endmodule

// File: tb/tb_mm2s_reader.sv
// Randomized bench for mm2s_reader: a transaction-level model (queues and counts) is
// compared against the DUT every cycle, plus literal checks for the directed cases.
module tb_mm2s_reader;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int LW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_start = 1'b0;
  logic          busy, done, arvalid, rready, out_valid, out_last;
  logic [AW-1:0] raddr;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          rvalid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;

  mm2s_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_start(cfg_start),
    .busy(busy), .done(done), .raddr(raddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            ar_pct = 100, or_pct = 100, rv_pct = 100;
  int            lat_min = 1, lat_max = 1;
  bit            ar_force_low = 0, or_force_low = 0;
  logic [DW-1:0] word_tab [64];
  resp_t         resp_q[$];
  logic [AW-1:0] ar_log[$];
  logic [DW:0]   beat_log[$];
  int            beat_cyc[$];
  int            done_count = 0;

  // Reference model state: transfer phase, latched config, in-flight reads and buffered words.
  int            m_state = 0;
  logic [AW-1:0] m_base = '0;
  int            m_len = 0, m_issued = 0, m_sent = 0, m_out = 0;
  logic [DW-1:0] fifo_q[$];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory and handshake partner: randomized readies, in-order read responses.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      arready   = ar_force_low ? 1'b0 : ($urandom_range(99) < ar_pct);
      out_ready = or_force_low ? 1'b0 : ($urandom_range(99) < or_pct);
      if (resp_q.size() > 0 && resp_q[0].due <= cyc && $urandom_range(99) < rv_pct) begin
        rvalid = 1'b1;
        rdata  = resp_q[0].data;
      end else begin
        rvalid = 1'b0;
        rdata  = '0;
      end
    end
  end

  // Compare process: check outputs against the model, then advance it by the coming edge.
  always @(negedge clk) begin
    logic          exp_arvalid, exp_rready, exp_ov, exp_last, ar_hs, r_hs, pop;
    logic [AW-1:0] exp_raddr;
    resp_t         r;
    if (!rst_n) begin
      check_output("reset_outs", 64'({busy, done, arvalid, rready, out_valid, out_last}), 64'd0);
      check_output("reset_raddr", 64'(raddr), 64'd0);
      check_output("reset_data", 64'(out_data), 64'd0);
      m_state = 0; m_issued = 0; m_sent = 0; m_out = 0; m_len = 0; m_base = '0;
      fifo_q.delete();
      if (rvalid && resp_q.size() > 0) void'(resp_q.pop_front());
    end else begin
      exp_arvalid = (m_state == 1) && (m_issued < m_len) && (m_out + fifo_q.size() < DEPTH);
      exp_raddr   = m_base + 32'(m_issued * (DW / 8));
      exp_rready  = (m_state == 1);
      exp_ov      = (fifo_q.size() > 0);
      exp_last    = exp_ov && (m_sent == m_len - 1);
      check_output("busy_done_rready", 64'({busy, done, rready}),
                   64'({m_state == 1, m_state == 2, exp_rready}));
      check_output("arvalid", 64'(arvalid), 64'(exp_arvalid));
      check_output("out_valid", 64'(out_valid), 64'(exp_ov));
      check_output("out_last", 64'(out_last), 64'(exp_last));
      if (exp_arvalid) check_output("raddr", 64'(raddr), 64'(exp_raddr));
      if (exp_ov) check_output("out_data", 64'(out_data), 64'(fifo_q[0]));
      if (done) done_count++;

      ar_hs = exp_arvalid && arready;
      r_hs  = exp_rready && rvalid;
      pop   = exp_ov && out_ready;
      if (rvalid && resp_q.size() > 0) void'(resp_q.pop_front());
      if (ar_hs) begin
        r.data = word_tab[m_issued];
        r.due  = cyc + $urandom_range(lat_max, lat_min);
        resp_q.push_back(r);
        ar_log.push_back(raddr);
        m_issued++;
        m_out++;
      end
      if (r_hs) begin
        fifo_q.push_back(rdata);
        m_out--;
      end
      if (pop) begin
        beat_log.push_back({out_last, out_data});
        beat_cyc.push_back(cyc);
        void'(fifo_q.pop_front());
        m_sent++;
      end
      if (m_state == 2) begin
        m_state = 0;
      end else if (m_state == 0 && cfg_start) begin
        m_base = cfg_base; m_len = int'(cfg_len);
        m_issued = 0; m_sent = 0; m_out = 0;
        m_state = (m_len == 0) ? 2 : 1;
      end else if (m_state == 1 && pop && m_sent == m_len) begin
        m_state = 2;
      end
    end
  end

  // Called at posedge+1; start is held for exactly one edge.
  task automatic apply_stimulus(input logic [AW-1:0] base, input int len);
    ar_log.delete(); beat_log.delete(); beat_cyc.delete();
    cfg_base = base; cfg_len = LW'(len); cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int start_count = done_count;
    for (int i = 0; i < bound && done_count == start_count; i++) begin
      @(posedge clk); #1;
    end
    check_output("done_pulses", 64'(done_count - start_count), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) word_tab[i] = $urandom;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    $display("[TB] nominal transfer");
    word_tab[0] = 32'h11; word_tab[1] = 32'h22; word_tab[2] = 32'h33; word_tab[3] = 32'h44;
    apply_stimulus(32'h1000, 4);
    wait_done(50);
    check_output("nom_ar_count", 64'(ar_log.size()), 64'd4);
    check_output("nom_beat_count", 64'(beat_log.size()), 64'd4);
    if (ar_log.size() == 4 && beat_log.size() == 4) begin
      check_output("nom_addr0", 64'(ar_log[0]), 64'h1000);
      check_output("nom_addr3", 64'(ar_log[3]), 64'h100C);
      check_output("nom_beat0", 64'(beat_log[0]), 64'h0_0000_0011);
      check_output("nom_beat2", 64'(beat_log[2]), 64'h0_0000_0033);
      check_output("nom_beat3", 64'(beat_log[3]), 64'h1_0000_0044);
      check_output("nom_back_to_back", 64'(beat_cyc[3] - beat_cyc[0]), 64'd3);
    end

    $display("[TB] backpressure");
    for (int i = 0; i < 64; i++) word_tab[i] = $urandom;
    or_force_low = 1;
    apply_stimulus(32'h2000, 8);
    idle(20);
    check_output("bp_ar_stalled", 64'(ar_log.size()), 64'd4);
    check_output("bp_arvalid_low", 64'(arvalid), 64'd0);
    or_force_low = 0;
    wait_done(100);
    check_output("bp_beats", 64'(beat_log.size()), 64'd8);
    for (int i = 0; i < beat_log.size() && i < 8; i++)
      check_output("bp_data", 64'(beat_log[i][DW-1:0]), 64'(word_tab[i]));

    $display("[TB] zero and one length");
    apply_stimulus(32'h3000, 0);
    wait_done(10);
    check_output("len0_ar", 64'(ar_log.size()), 64'd0);
    check_output("len0_beats", 64'(beat_log.size()), 64'd0);
    apply_stimulus(32'h3000, 1);
    wait_done(20);
    check_output("len1_beats", 64'(beat_log.size()), 64'd1);
    if (beat_log.size() == 1) check_output("len1_last", 64'(beat_log[0][DW]), 64'd1);

    $display("[TB] address stall and wrap");
    ar_force_low = 1;
    apply_stimulus(32'h4000, 3);
    for (int i = 0; i < 5; i++) begin
      check_output("stall_arvalid", 64'(arvalid), 64'd1);
      check_output("stall_raddr", 64'(raddr), 64'h4000);
      idle(1);
    end
    ar_force_low = 0;
    idle(1);
    check_output("stall_one_hs", 64'(ar_log.size()), 64'd1);
    wait_done(50);
    apply_stimulus(32'hFFFF_FFFC, 2);
    wait_done(50);
    if (ar_log.size() == 2) begin
      check_output("wrap_addr0", 64'(ar_log[0]), 64'hFFFF_FFFC);
      check_output("wrap_addr1", 64'(ar_log[1]), 64'h0);
    end else begin
      check_output("wrap_ar_count", 64'(ar_log.size()), 64'd2);
    end

    $display("[TB] start while busy");
    apply_stimulus(32'h5000, 6);
    idle(1);
    cfg_base = 32'h9000; cfg_len = 16'd2; cfg_start = 1'b1;
    idle(1);
    cfg_start = 1'b0;
    wait_done(80);
    check_output("busy_start_beats", 64'(beat_log.size()), 64'd6);
    if (ar_log.size() == 6) check_output("busy_start_addr5", 64'(ar_log[5]), 64'h5014);
    apply_stimulus(32'h6000, 2);
    check_output("restart_busy", 64'(busy), 64'd1);
    wait_done(50);
    check_output("restart_beats", 64'(beat_log.size()), 64'd2);

    $display("[TB] reset mid-run");
    lat_min = 4; lat_max = 4;
    apply_stimulus(32'h7000, 8);
    for (int i = 0; i < 100 && beat_log.size() < 2; i++) idle(1);
    check_output("rst_two_beats", 64'(beat_log.size()), 64'd2);
    rst_n = 1'b0;
    #1;
    check_output("rst_immediate", 64'({busy, arvalid, rready, out_valid, out_last}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(8);
    lat_min = 1; lat_max = 3;
    apply_stimulus(32'h7100, 3);
    wait_done(50);
    check_output("post_rst_beats", 64'(beat_log.size()), 64'd3);
    for (int i = 0; i < beat_log.size() && i < 3; i++)
      check_output("post_rst_data", 64'(beat_log[i][DW-1:0]), 64'(word_tab[i]));

    $display("[TB] randomized transfers");
    for (int t = 0; t < 12; t++) begin
      int len;
      for (int i = 0; i < 64; i++) word_tab[i] = $urandom;
      ar_pct = $urandom_range(100, 30);
      or_pct = $urandom_range(100, 30);
      rv_pct = $urandom_range(100, 30);
      lat_min = 1; lat_max = $urandom_range(4, 1);
      len = $urandom_range(30, 1);
      apply_stimulus($urandom & 32'hFFFF_FFFC, len);
      wait_done(3000);
      check_output("rand_beats", 64'(beat_log.size()), 64'(len));
      idle($urandom_range(3, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
